// File: rtl/serial_subtracter_unit.sv
// serial_subtracter_unit
//   Multi-cycle WIDTH-bit subtracter: difference = a - b - bin, with borrow-out.
//   BITS_PER_CYCLE bits are processed per RUN cycle, LSB slice first, through
//   an array of full-subtracter cells. The borrow between slices is kept in a
//   register. The partial result builds up internally. The outputs change only on
//   the completion edge or on reset.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN
//     When defined, adds overflow_o. This is the signed overflow of a - b - bin,
//     computed as (borrow into MSB cell) ^ (borrow out of MSB cell).
//
// Ports
//   clk_i         rising-edge clock
//   rst_n_i       asynchronous active-low reset
//   start_i       request; sampled only in IDLE or DONE
//   a_i, b_i      minuend / subtrahend, captured on accepted start
//   bin_i         borrow-in, captured on accepted start
//   busy_o        high while in RUN
//   done_o        one-cycle pulse, result valid
//   difference_o  last completed result
//   borrow_o      last completed borrow-out
//   overflow_o    last completed signed overflow (SERIAL_SUB_OVF_EN only)

// One full-subtracter bit cell.
module ssu_fs_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic br_i,
  output logic d_o,
  output logic br_o
);
  assign d_o  = x_i ^ y_i ^ br_i;
  assign br_o = (~x_i & y_i) | (~x_i & br_i) | (y_i & br_i);
endmodule

module serial_subtracter_unit #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] difference_o,
`ifdef SERIAL_SUB_OVF_EN
  output logic             borrow_o,
  output logic             overflow_o
`else
  output logic             borrow_o
`endif
);
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic             br_q;
  logic [CW-1:0]    cnt_q;

  logic [31:0]      base;
  logic [BPC-1:0]   x_sl, y_sl, d_sl;
  logic [BPC:0]     bc;
  logic             last;

  assign base = 32'(cnt_q) * 32'(BPC);
  assign x_sl = a_q[base +: BPC];
  assign y_sl = b_q[base +: BPC];
  assign bc[0] = br_q;
  assign last = (cnt_q == CW'(N - 1));

  // Borrow ripples across the slice through the cell array.
  ssu_fs_cell u_cell [BPC-1:0] (
    .x_i  (x_sl),
    .y_i  (y_sl),
    .br_i (bc[BPC-1:0]),
    .d_o  (d_sl),
    .br_o (bc[BPC:1])
  );

  // Merge the current slice into the accumulated partial result.
  always_comb begin
    res_d = res_q;
    res_d[base +: BPC] = d_sl;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      difference_o <= '0;
      borrow_o     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      overflow_o   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            br_q    <= bin_i;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_o  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          res_q <= res_d;
          br_q  <= bc[BPC];
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q      <= S_DONE;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            difference_o <= res_d;
            borrow_o     <= bc[BPC];
`ifdef SERIAL_SUB_OVF_EN
            // The MSB is the top cell of the last slice.
            overflow_o   <= bc[BPC] ^ bc[BPC-1];
`endif
          end
        end
        default: begin
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtracter_unit.sv
module tb_serial_subtracter_unit;
  typedef struct {
    logic [7:0] d;
    logic       bw;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0, start4 = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       bin = 1'b0;
  logic       busy1, done1, bor1, busy4, done4, bor4;
  logic [7:0] diff1, diff4;
  logic       ovf1, ovf4;
  int         n_cmp = 0, n_err = 0;
  exp_t       q1[$], q4[$];
  logic       pd1 = 1'b0, pd4 = 1'b0;

  always #5 clk = ~clk;

  serial_subtracter_unit #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .a_i(a), .b_i(b), .bin_i(bin),
    .busy_o(busy1), .done_o(done1), .difference_o(diff1),
`ifdef SERIAL_SUB_OVF_EN
    .borrow_o(bor1), .overflow_o(ovf1)
`else
    .borrow_o(bor1)
`endif
  );

  serial_subtracter_unit #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start4), .a_i(a), .b_i(b), .bin_i(bin),
    .busy_o(busy4), .done_o(done4), .difference_o(diff4),
`ifdef SERIAL_SUB_OVF_EN
    .borrow_o(bor4), .overflow_o(ovf4)
`else
    .borrow_o(bor4)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf1 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 9-bit unsigned subtract, plus signed-range overflow.
  function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    exp_t e;
    logic [8:0] r;
    int s;
    r = {1'b0, ta} - {1'b0, tb} - {8'd0, tbin};
    s = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
    e.d  = r[7:0];
    e.bw = r[8];
    e.ov = (s < -128) || (s > 127);
    return e;
  endfunction

  // Scoreboard: compare every done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done1) begin
      chk("pulse1", {31'd0, pd1}, 32'd0);
      if (q1.size() == 0) chk("spurious_done1", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("diff1", {24'd0, diff1}, {24'd0, e.d});
        chk("borrow1", {31'd0, bor1}, {31'd0, e.bw});
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf1", {31'd0, ovf1}, {31'd0, e.ov});
`endif
      end
    end
    if (rst_n && done4) begin
      chk("pulse4", {31'd0, pd4}, 32'd0);
      if (q4.size() == 0) chk("spurious_done4", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        chk("diff4", {24'd0, diff4}, {24'd0, e.d});
        chk("borrow4", {31'd0, bor4}, {31'd0, e.bw});
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf4", {31'd0, ovf4}, {31'd0, e.ov});
`endif
      end
    end
    pd1 = done1;
    pd4 = done4;
  end

  // Drive a start for one edge and queue the expected result.
  task automatic begin_op(input int which, input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    a = ta; b = tb; bin = tbin;
    if (which == 1) begin start1 = 1'b1; q1.push_back(model(ta, tb, tbin)); end
    else            begin start4 = 1'b1; q4.push_back(model(ta, tb, tbin)); end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Wait (bounded) for done; optionally check busy and latency from the start edge.
  task automatic wait_done(input int which, input bit check_lat);
    int n = (which == 1) ? 8 : 2;
    int cyc = 0;
    bit got = 1'b0;
    if (check_lat) chk("busy_after_start", {31'd0, (which == 1) ? busy1 : busy4}, 32'd1);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((which == 1) ? done1 : done4) begin
        cyc = i;
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    if (check_lat) chk("latency", cyc, n + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rbin;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_done1", {31'd0, done1}, 32'd0);
    chk("rst_diff1", {24'd0, diff1}, 32'd0);
    chk("rst_bor1", {31'd0, bor1}, 32'd0);
    chk("rst_ovf1", {31'd0, ovf1}, 32'd0);
    chk("rst_diff4", {24'd0, diff4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic op, then result holds after the pulse.
    begin_op(1, 8'h5A, 8'h23, 1'b0);
    wait_done(1, 1'b1);
    @(negedge clk);
    chk("done_low_after", {31'd0, done1}, 32'd0);
    chk("hold_diff", {24'd0, diff1}, 32'h37);
    chk("idle_busy", {31'd0, busy1}, 32'd0);
    @(posedge clk);
    #1;

    begin_op(1, 8'h00, 8'h01, 1'b0); wait_done(1, 1'b1); @(posedge clk); #1;
    begin_op(1, 8'h80, 8'h01, 1'b0); wait_done(1, 1'b1); @(posedge clk); #1;

    // Start re-pulsed mid-RUN with new operands must be ignored.
    begin_op(1, 8'h10, 8'h10, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    a = 8'h55; b = 8'h11; bin = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    wait_done(1, 1'b0);

    // Start held in the DONE cycle: next op starts with no IDLE gap.
    begin_op(1, 8'hC3, 8'h3C, 1'b1);
    wait_done(1, 1'b0);
    begin_op(1, 8'h7F, 8'h80, 1'b0);
    wait_done(1, 1'b1);
    @(posedge clk);
    #1;

    // Reset during the 4th RUN cycle discards the op.
    begin_op(1, 8'hAA, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q1.delete();
    #1;
    chk("midrst_busy", {31'd0, busy1}, 32'd0);
    chk("midrst_done", {31'd0, done1}, 32'd0);
    chk("midrst_diff", {24'd0, diff1}, 32'd0);
    chk("midrst_bor", {31'd0, bor1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_nodone", {31'd0, done1}, 32'd0);
    @(posedge clk);
    #1;
    begin_op(1, 8'h03, 8'h05, 1'b0); wait_done(1, 1'b1); @(posedge clk); #1;

    // Four bits per cycle.
    begin_op(4, 8'hF0, 8'h0F, 1'b0); wait_done(4, 1'b1); @(posedge clk); #1;
    begin_op(4, 8'h00, 8'h00, 1'b1); wait_done(4, 1'b1); @(posedge clk); #1;

    // Random sweep on both configurations.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      begin_op(1, ra, rb, rbin);
      wait_done(1, 1'b1);
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      begin_op(4, ra, rb, rbin);
      wait_done(4, 1'b1);
      @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
